// File: rtl/alu_unit.sv
// Single-cycle 32-bit integer ALU: add/sub/mul/div/rem/logic/shift/compare, both result words registered.
// Latency 1 cycle, a new operation accepted every cycle; there is no handshake and no backpressure.
module alu_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  op_select,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi
);

  typedef enum logic [3:0] {
    OP_IADD  = 4'h0, OP_ISUB  = 4'h1, OP_IMUL  = 4'h2, OP_IDIV  = 4'h3,
    OP_IREM  = 4'h4, OP_INEG  = 4'h5, OP_IAND  = 4'h6, OP_IOR   = 4'h7,
    OP_IXOR  = 4'h8, OP_ISHL  = 4'h9, OP_ISHR  = 4'hA, OP_IUSHR = 4'hB,
    OP_ICMP  = 4'hC, OP_PASSA = 4'hD, OP_PASSB = 4'hE, OP_NOP   = 4'hF
  } op_e;

  logic [31:0]        result_lo_d, result_lo_q;
  logic [31:0]        result_hi_d, result_hi_q;
  logic signed [31:0] a_s, b_s, div_b_s, quot_raw, rem_raw;
  logic signed [63:0] prod;
  logic [31:0]        quot, rem;
  logic [4:0]         shamt;
  logic               div_zero, div_ovf;

  always_comb begin
    a_s      = $signed(operand_a);
    b_s      = $signed(operand_b);
    shamt    = operand_b[4:0];
    prod     = $signed({{32{operand_a[31]}}, operand_a}) * $signed({{32{operand_b[31]}}, operand_b});
    div_zero = (operand_b == 32'h0);
    div_ovf  = (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
    // Divide by a harmless divisor in the corner cases so the divider never sees /0 or overflow.
    div_b_s  = (div_zero || div_ovf) ? 32'sd1 : b_s;
    quot_raw = a_s / div_b_s;
    rem_raw  = a_s % div_b_s;
    if (div_zero) begin
      quot = 32'h0;
      rem  = operand_a;
    end else if (div_ovf) begin
      quot = 32'h8000_0000;
      rem  = 32'h0;
    end else begin
      quot = quot_raw;
      rem  = rem_raw;
    end

    result_lo_d = 32'h0;
    result_hi_d = 32'h0;
    case (op_e'(op_select))
      OP_IADD:  result_lo_d = operand_a + operand_b;
      OP_ISUB:  result_lo_d = operand_a - operand_b;
      OP_IMUL:  {result_hi_d, result_lo_d} = prod;
      OP_IDIV:  begin
                  result_lo_d = quot;
                  result_hi_d = rem;
                end
      OP_IREM:  result_lo_d = rem;
      OP_INEG:  result_lo_d = 32'h0 - operand_a;
      OP_IAND:  result_lo_d = operand_a & operand_b;
      OP_IOR:   result_lo_d = operand_a | operand_b;
      OP_IXOR:  result_lo_d = operand_a ^ operand_b;
      OP_ISHL:  result_lo_d = operand_a << shamt;
      OP_ISHR:  result_lo_d = a_s >>> shamt;
      OP_IUSHR: result_lo_d = operand_a >> shamt;
      OP_ICMP:  begin
                  if (a_s < b_s)       result_lo_d = 32'hFFFF_FFFF;
                  else if (a_s == b_s) result_lo_d = 32'h0;
                  else                 result_lo_d = 32'h1;
                end
      OP_PASSA: result_lo_d = operand_a;
      OP_PASSB: result_lo_d = operand_b;
      default:  result_lo_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_lo_q <= 32'h0;
      result_hi_q <= 32'h0;
    end else begin
      result_lo_q <= result_lo_d;
      result_hi_q <= result_hi_d;
    end
  end

  assign result_lo = result_lo_q;
  assign result_hi = result_hi_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit with a queue scoreboard of expected {hi,lo} pairs.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] operand_a, operand_b;
  logic [3:0]  op_select;
  logic [31:0] result_lo, result_hi;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] exp_q[$];

  alu_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .op_select (op_select),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, push the expectation, then check #1 after the rising edge.
  task automatic step(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi);
    logic [63:0] e;
    @(negedge clk);
    op_select = op;
    operand_a = a;
    operand_b = b;
    exp_q.push_back({hi, lo});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".lo"}, result_lo, e[31:0]);
      check({tag, ".hi"}, result_hi, e[63:32]);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    operand_a = 32'h0;
    operand_b = 32'h0;
    op_select = 4'hF;
    #12;
    check("reset.lo", result_lo, 32'h0);
    check("reset.hi", result_hi, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step("iadd",       4'h0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 32'h0);
    step("iadd_wrap",  4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0);
    step("isub",       4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0);
    step("imul_neg",   4'h2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    step("imul_big",   4'h2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001);
    step("imul_nn",    4'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_000F, 32'h0);
    step("idiv",       4'h3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    step("idiv_zero",  4'h3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0005);
    step("idiv_ovf",   4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    step("idiv_negb",  4'h3, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    step("irem",       4'h4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0);
    step("irem_zero",  4'h4, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'h0);
    step("irem_ovf",   4'h4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0);
    step("ineg",       4'h5, 32'h0000_0005, 32'hDEAD_BEEF, 32'hFFFF_FFFB, 32'h0);
    step("iand",       4'h6, 32'h1215_3524, 32'hC089_5E81, 32'h0001_1400, 32'h0);
    step("ior",        4'h7, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 32'h0);
    step("ixor",       4'h8, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 32'h0);
    step("ishr",       4'hA, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 32'h0);
    step("iushr",      4'hB, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 32'h0);
    step("ishl",       4'h9, 32'h8000_0000, 32'h0000_0021, 32'h0000_0000, 32'h0);
    step("ishl_31",    4'h9, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    step("icmp_lt",    4'hC, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0);
    step("icmp_eq",    4'hC, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 32'h0);
    step("icmp_gt",    4'hC, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0);
    step("passa",      4'hD, 32'hCAFE_F00D, 32'h1234_5678, 32'hCAFE_F00D, 32'h0);
    step("passb",      4'hE, 32'hCAFE_F00D, 32'h1234_5678, 32'h1234_5678, 32'h0);
    step("nop",        4'hF, 32'hCAFE_F00D, 32'h1234_5678, 32'h0000_0000, 32'h0);

    // Reset mid-stream: outputs must clear between edges, then reload on the next edge.
    step("pre_rst",    4'h0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst.lo", result_lo, 32'h0);
    check("async_rst.hi", result_hi, 32'h0);
    #1;
    rst_n = 1'b1;
    step("post_rst",   4'h0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits, opcode width fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 operand_a  input  32  first operand; the value shifted for shift ops.
REQ-005 operand_b  input  32  second operand; shift amount source for shift ops.
REQ-006 op_select  input  4  operation code per REQ-010.
REQ-007 result_lo  output  32  registered low result word.
REQ-008 result_hi  output  32  registered high result word.

Function
REQ-009 The block SHALL register its outputs: on each rising clk edge with rst_n high, result_lo/result_hi SHALL load the results computed from the operand_a, operand_b and op_select values present before that edge (latency 1 cycle; no handshake; a new operation every cycle).
REQ-010 Opcode map; all operands are two's-complement signed unless stated otherwise:
  - 0x0 IADD: lo=a+b mod 2^32, hi=0.
  - 0x1 ISUB: lo=a-b mod 2^32, hi=0.
  - 0x2 IMUL: {hi,lo}=signed 64-bit product a*b.
  - 0x3 IDIV: lo=quotient truncated toward zero, hi=remainder.
  - 0x4 IREM: lo=remainder, hi=0.
  - 0x5 INEG: lo=-a mod 2^32, hi=0; b ignored.
  - 0x6 IAND: lo=a&b, hi=0.
  - 0x7 IOR: lo=a|b, hi=0.
  - 0x8 IXOR: lo=a^b, hi=0.
  - 0x9 ISHL: lo=a<<b[4:0], hi=0.
  - 0xA ISHR: lo=a arithmetic-shifted right by b[4:0], hi=0.
  - 0xB IUSHR: lo=a logical-shifted right by b[4:0], hi=0.
  - 0xC ICMP: lo=0xFFFFFFFF if a<b, 0 if a==b, 1 if a>b (signed); hi=0.
  - 0xD PASSA: lo=a, hi=0.
  - 0xE PASSB: lo=b, hi=0.
  - 0xF NOP: lo=0, hi=0.
REQ-011 The remainder SHALL take the sign of the dividend, so that a = q*b + r.
REQ-012 Overflow on add, sub, neg and mul-low SHALL wrap silently; no flags are produced.
REQ-013 Shift amounts SHALL use only b[4:0]; b[31:5] SHALL be ignored.
REQ-014 Division by zero: IDIV SHALL give lo=0, hi=a; IREM SHALL give lo=a, hi=0.
REQ-015 Divide overflow: a=0x80000000 with b=0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-016 Division SHALL complete within the single cycle, implemented as combinational logic; no stall or busy output exists.

Reset
REQ-017 While rst_n is low, result_lo and result_hi SHALL be 0x00000000, forced asynchronously without waiting for clk.
REQ-018 After rst_n deasserts, the first rising clk edge SHALL load a normal result; no state other than the output registers exists.

Verification
REQ-019 IAND: a=0x12153524, b=0xC0895E81, op=0x6 -> after 1 edge lo=0x00011400, hi=0.
REQ-020 IMUL: a=0xFFFFFFFF, b=0x00000002, op=0x2 -> lo=0xFFFFFFFE, hi=0xFFFFFFFF.
REQ-021 IDIV with divide-by-zero and overflow:
  - a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=5, b=0 -> lo=0, hi=5.
  - a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-022 Shifts: a=0x80000000, b=0x00000021:
  - ISHR -> lo=0xC0000000.
  - IUSHR -> lo=0x40000000.
  - ISHL -> lo=0x00000000.
REQ-023 ICMP: a=0xFFFFFFFF, b=1 -> lo=0xFFFFFFFF; a=b=7 -> lo=0; a=1, b=0xFFFFFFFF -> lo=1.
REQ-024 Reset mid-stream: drive IADD 3+4 and clock once (lo=7), then pull rst_n low between edges -> lo and hi go to 0 immediately; release -> next edge lo=7.
